// File: rtl/db_lookup_client.sv
// Flow-key lookup initiator: header in, one DB request at a time, drop/pass verdict out. Optional DB_CLIENT_STATS_EN adds event counters.
// Latency: request 1 cycle after header accept; verdict 1 cycle after response, TIMEOUT cycles after WAIT entry, or 1 cycle for non-UDP bypass.
// Backpressure: hdr_ready stays low from accept until the held verdict is taken with vd_ready.
module db_lookup_client #(
    parameter int KEY_SIZE  = 96,
    parameter int FLAG_SIZE = 4,
    parameter int TIMEOUT   = 1000,
    parameter int TMO_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hdr_valid,
    output logic                 hdr_ready,
    input  logic [31:0]          hdr_src_ip,
    input  logic [31:0]          hdr_dst_ip,
    input  logic [15:0]          hdr_dst_port,
    input  logic                 hdr_is_udp,
    input  logic [3:0]           hdr_op,
    output logic [KEY_SIZE-1:0]  db_in_key,
    output logic [FLAG_SIZE-1:0] db_in_flag,
    output logic                 db_in_valid,
    input  logic                 db_out_valid,
    input  logic [FLAG_SIZE-1:0] db_out_flag,
    output logic                 vd_valid,
    input  logic                 vd_ready,
    output logic                 vd_drop,
    output logic [3:0]           vd_code,
    output logic                 vd_timeout
`ifdef DB_CLIENT_STATS_EN
    ,
    input  logic                 stat_clr,
    output logic [31:0]          stat_req,
    output logic [31:0]          stat_hit,
    output logic [31:0]          stat_drop,
    output logic [31:0]          stat_tmo
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t           state;
    logic [TMO_W-1:0] tmo_cnt;
    logic             stale;
    logic             rsp_ok;
    logic             tmo_hit;

    function automatic logic is_drop(input logic [FLAG_SIZE-1:0] c);
        return (c == FLAG_SIZE'(2)) || (c == FLAG_SIZE'(3));
    endfunction

    // A live response beats a timeout landing in the same cycle.
    assign rsp_ok  = (state == S_WAIT) && db_out_valid && !stale;
    assign tmo_hit = (state == S_WAIT) && !rsp_ok && (tmo_cnt == TMO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            tmo_cnt     <= '0;
            stale       <= 1'b0;
            hdr_ready   <= 1'b0;
            db_in_key   <= '0;
            db_in_flag  <= '0;
            db_in_valid <= 1'b0;
            vd_valid    <= 1'b0;
            vd_drop     <= 1'b0;
            vd_code     <= '0;
            vd_timeout  <= 1'b0;
        end else begin
            // The first response after an abandoned request belongs to it; swallow it.
            if (db_out_valid && stale)
                stale <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (hdr_valid && hdr_ready) begin
                        hdr_ready <= 1'b0;
                        if (hdr_is_udp) begin
                            db_in_key   <= KEY_SIZE'({hdr_src_ip, hdr_dst_ip, hdr_dst_port, 16'h0000});
                            db_in_flag  <= FLAG_SIZE'(hdr_op);
                            db_in_valid <= 1'b1;
                            state       <= S_REQ;
                        end else begin
                            vd_valid   <= 1'b1;
                            vd_drop    <= 1'b0;
                            vd_code    <= '0;
                            vd_timeout <= 1'b0;
                            state      <= S_DONE;
                        end
                    end else begin
                        hdr_ready <= 1'b1;
                    end
                end
                S_REQ: begin
                    db_in_valid <= 1'b0;
                    tmo_cnt     <= '0;
                    state       <= S_WAIT;
                end
                S_WAIT: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (rsp_ok) begin
                        vd_valid   <= 1'b1;
                        vd_drop    <= is_drop(db_out_flag);
                        vd_code    <= 4'(db_out_flag);
                        vd_timeout <= 1'b0;
                        state      <= S_DONE;
                    end else if (tmo_hit) begin
                        vd_valid   <= 1'b1;
                        vd_drop    <= 1'b0;
                        vd_code    <= '0;
                        vd_timeout <= 1'b1;
                        stale      <= 1'b1;
                        state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (vd_ready) begin
                        vd_valid  <= 1'b0;
                        hdr_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef DB_CLIENT_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_req  <= '0;
            stat_hit  <= '0;
            stat_drop <= '0;
            stat_tmo  <= '0;
        end else if (stat_clr) begin
            stat_req  <= '0;
            stat_hit  <= '0;
            stat_drop <= '0;
            stat_tmo  <= '0;
        end else begin
            if (state == S_REQ)
                stat_req <= stat_req + 32'd1;
            if (rsp_ok && (db_out_flag != '0))
                stat_hit <= stat_hit + 32'd1;
            if (rsp_ok && is_drop(db_out_flag))
                stat_drop <= stat_drop + 32'd1;
            if (tmo_hit)
                stat_tmo <= stat_tmo + 32'd1;
        end
    end
`endif

endmodule
